// File: rtl/regfile_mp_pkg.sv
// Shared defaults and slicing helper for the multi-port register file.
// Every file of the register file imports this package.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

  // Low bit of port p's field inside a flat per-port vector.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file.
// There is no valid/ready handshake: every signal is sampled on every rising
// edge. rd_en, wr_en, alloc_en and flush act as one-cycle commands, and
// rs_data/rs_busy are valid after the edge that captured the addresses.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);

  localparam int AW = $clog2(NREGS);

  logic                 rd_en;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_data;
  logic [NRD-1:0]       rs_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic                 flush;

  modport master (
    output rd_en, rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rs_data, rs_busy
  );

  modport slave (
    input  rd_en, rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rs_data, rs_busy
  );

endinterface

// File: rtl/regfile_mp_rdport.sv
// One read port: captured address plus a data register that tracks the
// architectural value of that address, including same-edge writes.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [AW-1:0]   cap,
  output logic [XLEN-1:0] data
);

  // wr_en arrives already qualified with a nonzero destination.
  logic hit_new;
  logic hit_cap;

  assign hit_new = wr_en && (wr_addr == addr);
  assign hit_cap = wr_en && (wr_addr == cap);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap  <= '0;
      data <= '0;
    end else if (rd_en) begin
      cap  <= addr;
      data <= hit_new ? wr_data : arr_data;
    end else if (hit_cap) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, write-first bypass
// and a per-register busy scoreboard for decode hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_next;
  logic                       wr_live;

  // x0 is never written, so after reset it reads as zero forever.
  assign wr_live = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_live) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Priority: flush, then allocation, then writeback clear.
  always_comb begin
    busy_next = busy;
    if (bus.wr_en) begin
      busy_next[bus.wr_addr] = 1'b0;
    end
    if (bus.alloc_en) begin
      busy_next[bus.alloc_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_next = '0;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0]   addr;
    logic [AW-1:0]   cap;
    logic [XLEN-1:0] data;

    assign addr = bus.rs_addr[slice_lo(p, AW) +: AW];

    regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (bus.rd_en),
      .addr     (addr),
      .arr_data (regs[addr]),
      .wr_en    (wr_live),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .cap      (cap),
      .data     (data)
    );

    assign bus.rs_data[slice_lo(p, XLEN) +: XLEN] = data;
    assign bus.rs_busy[p]                         = busy[cap];
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with registered read data, write-to-read bypass and a per-register busy scoreboard. It serves the decode stage (read ports, issue-time allocation) and the writeback stage (write port, busy clear). It replaces the single-pair register file in wider or dual-issue pipelines and gives decode a direct load-use/RAW hazard indication.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; a power of two, at least 2
- NRD, 2, number of read ports, 1 to 4
- AW, $clog2(NREGS), address width; derived, not overridden

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read capture enable, shared by all read ports
- rs_addr  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW]
- rs_data  out  NRD*XLEN  registered read data per port
- rs_busy  out  NRD  busy bit of each port's captured address
- wr_en  in  1  writeback write enable
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- alloc_en  in  1  issue-time allocation: marks alloc_addr busy
- alloc_addr  in  AW  register being allocated
- flush  in  1  clears all busy bits; register contents untouched

## Operation
- Register 0 is hard-wired zero. Writes to it are discarded, it can never be busy, and reads of it return 0.
- Each read port p holds a captured address cap[p] and a data register rs_data[p].
- When rd_en=1, cap[p] is loaded with rs_addr[p] at the edge.
- The data register always equals the architectural value of the captured address as of the preceding edge:
  - on a capture edge, rs_data[p] loads the array value of rs_addr[p], or wr_data if wr_en=1, wr_addr=rs_addr[p] and wr_addr≠0 (write-first bypass);
  - when rd_en=0, rs_data[p] holds, except that a write hitting cap[p] (nonzero) reloads rs_data[p] with wr_data at the same edge.
- Array write: when wr_en=1 and wr_addr≠0, the register is updated at the edge.
- Busy vector, bit 0 forced 0. Next value per register r:
  - 0 if flush=1;
  - else 1 if alloc_en=1 and alloc_addr=r (allocation wins over a same-cycle clear);
  - else 0 if wr_en=1 and wr_addr=r;
  - else unchanged.
- rs_busy[p] = busy[cap[p]], combinational from registered state.
- A write to a register that is not busy is legal and updates the array normally.

## Timing
- Reset (rst=1 at an edge): all registers, cap[p], rs_data and busy are set to 0, so rs_busy=0. Reset overrides all inputs in that cycle. Asserting reset mid-operation discards in-flight allocations.
- Read latency is 1 cycle: addresses presented at edge n give data and busy valid after edge n.
- Write visibility is 1 edge: a write at edge n is seen by every port reading or holding that address immediately after edge n, with no stale cycle.
- Allocation at edge n makes rs_busy high after edge n for ports holding that address. A clear at edge n drops it after edge n.
- Multiple ports may read the same address; all must return identical data.
- No handshake; every input is sampled on every edge.

## Structure
- Shared package regfile_pkg holds XLEN_DEF, NREGS_DEF, ZERO_REG=0 and helper localparams for port slicing.
- Sub-module regfile_rdport holds one port's capture, bypass and hold-refresh logic and is instantiated NRD times in a generate loop.
- The array and busy vector stay in the top module.

## Test plan
- Reset, then read x0..x3 on both ports -> rs_data=0 and rs_busy=0 one cycle later. Writing 0xDEAD_BEEF to x0 -> still reads 0.
- Same-edge bypass: wr x5=0x1234_5678 with rd_en=1 and rs_addr={5,5} -> both ports return 0x1234_5678 after that edge.
- Hold refresh: capture x7 (=0x11), then rd_en=0, then write x7=0x22 -> rs_data updates to 0x22 after the write edge while rd_en stays 0.
- Scoreboard: alloc x9 -> rs_busy=1 for a port holding 9. Later wr x9 -> busy 0. Alloc x9 and wr x9 on the same edge -> busy stays 1.
- flush with x3, x4 and x9 busy -> all busy bits 0 next cycle, array contents preserved. Alloc x0 -> rs_busy stays 0.
- Reset mid-stream with x6 busy and x6=0xAA -> next cycle x6 reads 0 and busy is 0. NRD=4 and NREGS=16 variants rerun the first four scenarios.
